mc_datapath: RTL and testbench
==============================

MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: ImmSrc  input  2  immediate format select.
REQ-005 Port: ALUSrcA, ALUSrcB  input  2 each  ALU operand selects.
REQ-006 Port: ResultSrc  input  2  result bus select.
REQ-007 Port: AdrSrc  input  1  memory address select.
REQ-008 Port: ALUControl  input  3  ALU operation.
REQ-009 Port: IRWrite, PCWrite, RegWrite  input  1 each  register enables.
REQ-010 Port: ReadData  input  32  memory read data, valid in the same cycle as Adr.
REQ-011 Port: op  output  7; funct3  output  3; funct7b5  output  1; Zero  output  1  controller feedback.
REQ-012 Port: Adr  output  32; WriteData  output  32  memory address and store data.

Function
REQ-013 PC: loads Result on a rising clk when PCWrite=1; otherwise holds.
REQ-014 IRWrite=1: OldPC <= PC (pre-update value, even if PCWrite=1 in the same cycle); Instr <= ReadData.
REQ-015 Data <= ReadData, A <= RD1, B <= RD2, ALUOut <= ALUResult every cycle, unconditionally.
REQ-016 Adr = AdrSrc ? Result : PC; WriteData = B; both combinational.
REQ-017 SrcA: 00 PC, 01 OldPC, 10 A, 11 32'h0.
REQ-018 SrcB: 00 B, 01 ImmExt, 10 32'd4, 11 32'h0.
REQ-019 Result: 00 ALUOut, 01 Data, 10 ALUResult, 11 32'h0.
REQ-020 ImmExt: 00 I sign-ext Instr[31:20]; 01 S {Instr[31:25],Instr[11:7]}; 10 B {Instr[31],Instr[7],Instr[30:25],Instr[11:8],0}; 11 J {Instr[31],Instr[19:12],Instr[20],Instr[30:21],0}; all sign-extended from Instr[31].
REQ-021 ALU: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed, per REQ-031); all other codes yield 0; add/sub wrap modulo 2^32, no overflow flag.
REQ-022 Zero = (ALUResult == 0), combinational.
REQ-023 op = Instr[6:0], funct3 = Instr[14:12], funct7b5 = Instr[30].
REQ-024 Register file: 32x32; combinational reads at rs1 = Instr[19:15] and rs2 = Instr[24:20]; synchronous write of Result to rd = Instr[11:7] when RegWrite=1.
REQ-025 x0: reads always return 0; writes are discarded.
REQ-026 Same-cycle write and read of one register: the read returns the old value; there is no bypass.
REQ-027 Write-enable and Instr are sampled at the same edge; rd is taken from Instr as held before that edge.

Reset
REQ-028 reset=1 asynchronously sets PC=RESET_PC and clears OldPC, Instr, Data, A, B, ALUOut and all 32 registers to 0.
REQ-029 While reset=1: op=0, funct3=0, funct7b5=0, Adr=RESET_PC, WriteData=0.
REQ-030 Reset asserted mid-instruction aborts that instruction with no further register or PC update; the first edge after deassertion behaves as a normal fetch edge.

Configuration
REQ-031 Macro MC_DATAPATH_SLT_EN: when defined, ALUControl=101 yields {31'b0, signed(SrcA)<signed(SrcB)}; when undefined, 101 yields 0, and Zero=1 with ALU inputs otherwise unchanged.

Structure
REQ-032 A shared package holds: the ALUControl, ImmSrc, ALUSrcA/B and ResultSrc encodings as enums; RESET_PC default; register count 32.
REQ-033 Sub-module regfile32 implements the register file (REQ-024..027); the ALU, extend logic and muxes are inline.

Verification
REQ-034 Reset, then IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ReadData=32'h00500093 -> PC=4, OldPC=0, op=7'h13, funct3=0.
REQ-035 Using the instruction from REQ-034 (addi x1,x0,5): decode then ALUSrcA=10, ALUSrcB=01, ALUControl=000, then ResultSrc=00, RegWrite=1 -> x1=5, observed via A on the next instruction with rs1=1.
REQ-036 Write rd=0 with Result=32'hDEAD_BEEF -> a subsequent read of x0 gives 0.
REQ-037 A=5, B=5, ALUControl=001 -> Zero=1; A=32'h8000_0000, B=1, sub -> ALUResult=32'h7FFF_FFFF (wrap); with MC_DATAPATH_SLT_EN, A=-1, B=1, 101 -> ALUResult=1; without it -> 0.
REQ-038 Instr=32'hFE000EE3, ImmSrc=10 -> ImmExt=32'hFFFF_FFFC; ImmSrc=11 on 32'h0000_006F -> ImmExt=0.
REQ-039 Assert reset with PC=32'h20 and RegWrite=1 pending -> PC=RESET_PC immediately, no register written, all registers read 0.

Source files
------------

// File: rtl/mc_datapath_pkg.sv
// Shared encodings and constants for the multicycle RISC-V datapath (mc_datapath).
package mc_datapath_pkg;

    localparam int          NUM_REGS         = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctl_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_A     = 2'b10,
        SRCA_ZERO  = 2'b11
    } src_a_e;

    typedef enum logic [1:0] {
        SRCB_B    = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10,
        SRCB_ZERO = 2'b11
    } src_b_e;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10,
        RES_ZERO      = 2'b11
    } result_src_e;

endpackage

// File: rtl/mc_datapath_regfile32.sv
// 32x32 register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
module regfile32
    import mc_datapath_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we && (wa != 5'd0)) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see the pre-edge contents; a write in the same cycle is not forwarded.
    assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs_q[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs_q[ra2];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle RISC-V datapath: PC/IR/operand registers, inline extend, ALU and muxes.
// Optional signed set-less-than on ALUControl=101 when MC_DATAPATH_SLT_EN is defined.
module mc_datapath
    import mc_datapath_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ImmSrc,
    input  logic [1:0]  ALUSrcA,
    input  logic [1:0]  ALUSrcB,
    input  logic [1:0]  ResultSrc,
    input  logic        AdrSrc,
    input  logic [2:0]  ALUControl,
    input  logic        IRWrite,
    input  logic        PCWrite,
    input  logic        RegWrite,
    input  logic [31:0] ReadData,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic        Zero,
    output logic [31:0] Adr,
    output logic [31:0] WriteData
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] old_pc_q, old_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_out_q, alu_out_d;

    logic [31:0] rd1, rd2;
    logic [31:0] imm_ext;
    logic [31:0] src_a, src_b;
    logic [31:0] alu_result;
    logic [31:0] result;

`ifdef MC_DATAPATH_SLT_EN
    function automatic logic slt_signed(input logic signed [31:0] x, input logic signed [31:0] y);
        return x < y;
    endfunction
`endif

    regfile32 u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (RegWrite),
        .ra1   (instr_q[19:15]),
        .ra2   (instr_q[24:20]),
        .wa    (instr_q[11:7]),
        .wd    (result),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    always_comb begin
        imm_ext = '0;
        case (imm_src_e'(ImmSrc))
            IMM_I: imm_ext = {{20{instr_q[31]}}, instr_q[31:20]};
            IMM_S: imm_ext = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            IMM_B: imm_ext = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
            IMM_J: imm_ext = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
        endcase
    end

    always_comb begin
        src_a = '0;
        case (src_a_e'(ALUSrcA))
            SRCA_PC:    src_a = pc_q;
            SRCA_OLDPC: src_a = old_pc_q;
            SRCA_A:     src_a = a_q;
            SRCA_ZERO:  src_a = 32'h0;
        endcase
    end

    always_comb begin
        src_b = '0;
        case (src_b_e'(ALUSrcB))
            SRCB_B:    src_b = b_q;
            SRCB_IMM:  src_b = imm_ext;
            SRCB_FOUR: src_b = 32'd4;
            SRCB_ZERO: src_b = 32'h0;
        endcase
    end

    // Add/sub wrap modulo 2^32; unassigned codes produce zero.
    always_comb begin
        alu_result = '0;
        case (alu_ctl_e'(ALUControl))
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
`ifdef MC_DATAPATH_SLT_EN
            ALU_SLT: alu_result = {31'b0, slt_signed(src_a, src_b)};
`endif
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        result = '0;
        case (result_src_e'(ResultSrc))
            RES_ALUOUT:    result = alu_out_q;
            RES_DATA:      result = data_q;
            RES_ALURESULT: result = alu_result;
            RES_ZERO:      result = 32'h0;
        endcase
    end

    always_comb begin
        pc_d      = PCWrite ? result : pc_q;
        old_pc_d  = IRWrite ? pc_q : old_pc_q;
        instr_d   = IRWrite ? ReadData : instr_q;
        data_d    = ReadData;
        a_d       = rd1;
        b_d       = rd2;
        alu_out_d = alu_result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            old_pc_q  <= '0;
            instr_q   <= '0;
            data_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
        end else begin
            pc_q      <= pc_d;
            old_pc_q  <= old_pc_d;
            instr_q   <= instr_d;
            data_q    <= data_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
        end
    end

    // While in reset the address bus presents the reset vector regardless of AdrSrc.
    assign Adr       = reset ? RESET_PC : (AdrSrc ? result : pc_q);
    assign WriteData = b_q;
    assign Zero      = (alu_result == 32'h0);
    assign op        = instr_q[6:0];
    assign funct3    = instr_q[14:12];
    assign funct7b5  = instr_q[30];

endmodule

// File: tb/tb_mc_datapath.sv
// Randomized and directed bench for mc_datapath against an architectural-state model.
module tb_mc_datapath;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef MC_DATAPATH_SLT_EN
    localparam bit SLT_EN = 1'b1;
`else
    localparam bit SLT_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic        AdrSrc;
    logic [2:0]  ALUControl;
    logic        IRWrite, PCWrite, RegWrite;
    logic [31:0] ReadData;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5, Zero;
    logic [31:0] Adr, WriteData;

    int n_checks;
    int n_fail;

    // architectural state of the model
    logic [31:0] m_pc, m_oldpc, m_instr, m_data, m_a, m_b, m_aluout;
    logic [31:0] m_regs [32];

    mc_datapath #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .ALUControl(ALUControl), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ReadData(ReadData), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero), .Adr(Adr), .WriteData(WriteData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_imm(input logic [31:0] i, input logic [1:0] s);
        case (s)
            2'd0:    return {{20{i[31]}}, i[31:20]};
            2'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            2'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] m_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return (SLT_EN && ($signed(a) < $signed(b))) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_alu_result();
        logic [31:0] sa, sb;
        case (ALUSrcA)
            2'd0: sa = m_pc;
            2'd1: sa = m_oldpc;
            2'd2: sa = m_a;
            default: sa = 32'h0;
        endcase
        case (ALUSrcB)
            2'd0: sb = m_b;
            2'd1: sb = m_imm(m_instr, ImmSrc);
            2'd2: sb = 32'd4;
            default: sb = 32'h0;
        endcase
        return m_alu(sa, sb, ALUControl);
    endfunction

    function automatic logic [31:0] m_result();
        case (ResultSrc)
            2'd0: return m_aluout;
            2'd1: return m_data;
            2'd2: return m_alu_result();
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : m_regs[idx];
    endfunction

    task automatic m_clear();
        m_pc = RST_PC; m_oldpc = 0; m_instr = 0; m_data = 0; m_a = 0; m_b = 0; m_aluout = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask

    task automatic model_check();
        logic [31:0] exp_adr;
        exp_adr = reset ? RST_PC : (AdrSrc ? m_result() : m_pc);
        check32("adr", Adr, exp_adr);
        check32("write_data", WriteData, m_b);
        check32("zero", {31'b0, Zero}, {31'b0, (m_alu_result() == 32'h0)});
        check32("op", {25'b0, op}, {25'b0, m_instr[6:0]});
        check32("funct3", {29'b0, funct3}, {29'b0, m_instr[14:12]});
        check32("funct7b5", {31'b0, funct7b5}, {31'b0, m_instr[30]});
    endtask

    task automatic model_update();
        logic [31:0] res, alu, na, nb;
        logic [4:0]  rd;
        res = m_result();
        alu = m_alu_result();
        na  = m_read(m_instr[19:15]);
        nb  = m_read(m_instr[24:20]);
        rd  = m_instr[11:7];
        if (RegWrite && rd != 5'd0) m_regs[rd] = res;
        if (IRWrite) begin
            m_oldpc = m_pc;
            m_instr = ReadData;
        end
        if (PCWrite) m_pc = res;
        m_data = ReadData; m_a = na; m_b = nb; m_aluout = alu;
    endtask

    task automatic cycle();
        #2;
        model_check();
        @(posedge clk);
        if (!reset) model_update();
        #1;
    endtask

    task automatic idle();
        ImmSrc = 0; ALUSrcA = 0; ALUSrcB = 0; ResultSrc = 0; AdrSrc = 0; ALUControl = 0;
        IRWrite = 0; PCWrite = 0; RegWrite = 0; ReadData = 0;
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        #1;
        m_clear();
        check32("rst_adr", Adr, RST_PC);
        check32("rst_write_data", WriteData, 32'h0);
        check32("rst_op", {25'b0, op}, 32'h0);
        check32("rst_funct3", {29'b0, funct3}, 32'h0);
        check32("rst_funct7b5", {31'b0, funct7b5}, 32'h0);
        model_check();
        @(posedge clk);
        #1;
        model_check();
        #1;
        reset = 1'b0;
    endtask

    task automatic load_instr(input logic [31:0] w);
        idle(); IRWrite = 1; ReadData = w; cycle();
        idle(); cycle();
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
        load_instr({20'h0, rd, 7'h13});
        idle(); ReadData = val; cycle();
        idle(); ResultSrc = 2'd1; RegWrite = 1; cycle();
        idle();
    endtask

    task automatic set_rs(input logic [4:0] rs1, input logic [4:0] rs2);
        load_instr({7'h0, rs2, rs1, 3'h0, 5'h0, 7'h33});
    endtask

    task automatic expect_alu(input string name, input logic [1:0] sa, input logic [1:0] sb,
                              input logic [2:0] ctl, input logic [31:0] exp);
        idle(); ALUSrcA = sa; ALUSrcB = sb; ALUControl = ctl; ResultSrc = 2'd2; AdrSrc = 1;
        #1;
        check32(name, Adr, exp);
        cycle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        reset = 1'b1;
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        check32("reset_adr", Adr, RST_PC);
        check32("reset_write_data", WriteData, 32'h0);
        check32("reset_op", {25'b0, op}, 32'h0);
        #2;
        reset = 1'b0;

        // fetch of addi x1,x0,5
        idle(); IRWrite = 1; PCWrite = 1; ALUSrcB = 2'd2; ResultSrc = 2'd2; ReadData = 32'h0050_0093;
        cycle();
        idle();
        #1;
        check32("fetch_pc", Adr, 32'd4);
        check32("fetch_op", {25'b0, op}, 32'h13);
        check32("fetch_funct3", {29'b0, funct3}, 32'h0);
        expect_alu("fetch_oldpc", 2'd1, 2'd3, 3'd0, 32'h0);

        // execute and writeback of addi
        expect_alu("addi_exec", 2'd2, 2'd1, 3'd0, 32'd5);
        idle(); ALUSrcA = 2'd2; ALUSrcB = 2'd1; ResultSrc = 2'd0; RegWrite = 1; AdrSrc = 1;
        #1;
        check32("addi_aluout", Adr, 32'd5);
        cycle();
        set_rs(5'd1, 5'd0);
        expect_alu("x1_via_a", 2'd2, 2'd3, 3'd0, 32'd5);

        // x0 stays zero
        load_instr(32'h0000_0013);
        idle(); ReadData = 32'hDEAD_BEEF; cycle();
        idle(); ResultSrc = 2'd1; RegWrite = 1; AdrSrc = 1;
        #1;
        check32("x0_wr_data", Adr, 32'hDEAD_BEEF);
        cycle();
        idle(); cycle();
        check32("x0_read_b", WriteData, 32'h0);
        expect_alu("x0_read_a", 2'd2, 2'd3, 3'd0, 32'h0);

        // ALU corners
        set_rs(5'd1, 5'd1);
        idle(); ALUSrcA = 2'd2; ALUSrcB = 2'd0; ALUControl = 3'd1;
        #1;
        check32("sub_zero", {31'b0, Zero}, 32'd1);
        check32("b_is_5", WriteData, 32'd5);
        cycle();
        write_reg(5'd4, 32'h8000_0000);
        write_reg(5'd5, 32'h0000_0001);
        set_rs(5'd4, 5'd5);
        expect_alu("sub_wrap", 2'd2, 2'd0, 3'd1, 32'h7FFF_FFFF);
        expect_alu("or_op", 2'd2, 2'd0, 3'd3, 32'h8000_0001);
        expect_alu("and_op", 2'd2, 2'd0, 3'd2, 32'h0);
        write_reg(5'd6, 32'hFFFF_FFFF);
        set_rs(5'd6, 5'd5);
        expect_alu("slt_neg", 2'd2, 2'd0, 3'd5, SLT_EN ? 32'd1 : 32'd0);
        expect_alu("unused_code", 2'd2, 2'd0, 3'd7, 32'h0);
        set_rs(5'd5, 5'd6);
        expect_alu("slt_pos", 2'd2, 2'd0, 3'd5, 32'h0);

        // immediate formats
        load_instr(32'hFE00_0EE3);
        idle(); ImmSrc = 2'd2; ALUSrcA = 2'd3; ALUSrcB = 2'd1; ResultSrc = 2'd2; AdrSrc = 1;
        #1;
        check32("imm_b", Adr, 32'hFFFF_FFFC);
        ImmSrc = 2'd0;
        #1;
        check32("imm_i", Adr, 32'hFFFF_FFE0);
        ImmSrc = 2'd1;
        #1;
        check32("imm_s", Adr, 32'hFFFF_FFFD);
        cycle();
        load_instr(32'h0000_006F);
        idle(); ImmSrc = 2'd3; ALUSrcA = 2'd3; ALUSrcB = 2'd1; ResultSrc = 2'd2; AdrSrc = 1;
        #1;
        check32("imm_j", Adr, 32'h0);
        cycle();

        // reset aborts a pending write
        idle(); ReadData = 32'h20; cycle();
        idle(); ResultSrc = 2'd1; PCWrite = 1; cycle();
        idle();
        #1;
        check32("pc_20", Adr, 32'h20);
        load_instr(32'h0000_0393);
        idle(); ResultSrc = 2'd2; ALUSrcB = 2'd2; RegWrite = 1; PCWrite = 1;
        pulse_reset();
        idle();
        #1;
        check32("post_reset_pc", Adr, RST_PC);
        set_rs(5'd1, 5'd7);
        check32("post_reset_x7", WriteData, 32'h0);
        expect_alu("post_reset_x1", 2'd2, 2'd3, 3'd0, 32'h0);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            ImmSrc     = 2'($urandom_range(0, 3));
            ALUSrcA    = 2'($urandom_range(0, 3));
            ALUSrcB    = 2'($urandom_range(0, 3));
            ResultSrc  = 2'($urandom_range(0, 3));
            AdrSrc     = 1'($urandom_range(0, 1));
            ALUControl = 3'($urandom_range(0, 7));
            IRWrite    = 1'($urandom_range(0, 1));
            PCWrite    = 1'($urandom_range(0, 1));
            RegWrite   = 1'($urandom_range(0, 1));
            ReadData   = $urandom;
            if ($urandom_range(0, 63) == 0) pulse_reset();
            else cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
